mac_accumulator: RTL and testbench

Accumulates the 14-bit signed column sums emitted by the final carry-save adder of the multiplier tree, one beat per cycle, over a configurable number of terms (one kernel window). When the window completes, it adds a bias, rounds, scales by a fixed right shift, optionally applies ReLU, saturates to an 8-bit activation, and offers the result on a valid/ready output. It sits directly downstream of the adder tree and upstream of the activation write-back path.

---
 rtl/npu_pkg.sv | 22 ++
 rtl/mac_accumulator_if.sv | 34 +++
 rtl/sat_relu.sv | 38 +++
 rtl/mac_accumulator.sv | 111 +++++++++++
 tb/tb_mac_accumulator.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/npu_pkg.sv
// Shared constants and types for the NPU post-processing stages.
// The MAC accumulator and the saturation/ReLU helper both build on these widths.
package npu_pkg;

  localparam int IN_W          = 14;
  localparam int ACC_W         = 24;
  localparam int OUT_W         = 8;
  localparam int LEN_W         = 8;
  localparam int SHIFT_DEFAULT = 6;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    OUT
  } state_t;

  // A programmed window length of zero still consumes one beat.
  function automatic logic [LEN_W-1:0] effLen(input logic [LEN_W-1:0] len);
    return (len == '0) ? LEN_W'(1) : len;
  endfunction

endpackage

// File: rtl/mac_accumulator_if.sv
// Input beat stream and output result handshake of the MAC accumulator.
// The DUT uses the slave modport; the producer/consumer side uses master.
interface mac_accumulator_if;
  import npu_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_sat;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_sat
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_sat
  );

endinterface

// File: rtl/sat_relu.sv
// Rounds, scales, optionally rectifies and saturates an accumulator value.
// Purely combinational so other post-processing stages can reuse it.
module sat_relu #(
  parameter int ACC_W = npu_pkg::ACC_W,
  parameter int OUT_W = npu_pkg::OUT_W,
  parameter int SHIFT = npu_pkg::SHIFT_DEFAULT
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic                    relu,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_sat
);

  // One extra bit keeps the half-up rounding term from wrapping the sum.
  localparam logic signed [ACC_W:0] RND  = (ACC_W+1)'((64'(1) << SHIFT) >> 1);
  localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'((2 ** (OUT_W-1)) - 1);
  localparam logic signed [ACC_W:0] MINV = (ACC_W+1)'(-(2 ** (OUT_W-1)));

  logic signed [ACC_W:0] rounded;
  logic signed [ACC_W:0] shifted;
  logic signed [ACC_W:0] clipped;

  always_comb begin
    rounded  = {acc[ACC_W-1], acc} + RND;
    shifted  = rounded >>> SHIFT;
    clipped  = (relu && shifted[ACC_W]) ? '0 : shifted;
    out_sat  = 1'b0;
    out_data = clipped[OUT_W-1:0];
    if (clipped > MAXV) begin
      out_data = MAXV[OUT_W-1:0];
      out_sat  = 1'b1;
    end else if (clipped < MINV) begin
      out_data = MINV[OUT_W-1:0];
      out_sat  = 1'b1;
    end
  end

endmodule

// File: rtl/mac_accumulator.sv
// Accumulates one kernel window of adder-tree sums, then offers a biased,
// rounded, scaled and saturated activation on a valid/ready output.
module mac_accumulator
  import npu_pkg::*;
#(
  parameter int SHIFT = SHIFT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [LEN_W-1:0]        cfg_len,
  input  logic signed [ACC_W-1:0] cfg_bias,
  input  logic                    cfg_relu,
  mac_accumulator_if.slave        bus,
  output logic                    busy
);

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0]        cnt_q, cnt_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic                    relu_q, relu_d;
  logic signed [OUT_W-1:0] outData_q;
  logic                    outSat_q;

  logic signed [ACC_W-1:0] inExt;
  logic signed [OUT_W-1:0] satData;
  logic                    satFlag;
  logic                    loadResult;

  assign inExt      = {{(ACC_W-IN_W){bus.in_data[IN_W-1]}}, bus.in_data};
  assign loadResult = (state_d == OUT) && (state_q != OUT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      relu_q    <= 1'b0;
      outData_q <= '0;
      outSat_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      relu_q  <= relu_d;
      if (loadResult) begin
        outData_q <= satData;
        outSat_q  <= satFlag;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    relu_d  = relu_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          len_d   = effLen(cfg_len);
          relu_d  = cfg_relu;
          acc_d   = cfg_bias + inExt;
          cnt_d   = LEN_W'(1);
          state_d = (len_d == LEN_W'(1)) ? OUT : ACC;
        end
      end
      ACC: begin
        if (bus.in_valid) begin
          acc_d = acc_q + inExt;
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_d == len_q) begin
            state_d = OUT;
          end
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The result is formed from the next-state accumulator so it is ready on entry to OUT.
  sat_relu #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_sat_relu (
    .acc      (acc_d),
    .relu     (relu_d),
    .out_data (satData),
    .out_sat  (satFlag)
  );

  always_comb begin
    bus.in_ready  = (state_q != OUT);
    bus.out_valid = (state_q == OUT);
    bus.out_data  = outData_q;
    bus.out_sat   = outSat_q;
    busy          = (state_q != IDLE);
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed and randomized windows for mac_accumulator, checked against an
// arithmetic reference model of the window result.
module tb_mac_accumulator;
  import npu_pkg::*;

  localparam int SHIFT = SHIFT_DEFAULT;

  logic                    clk;
  logic                    reset_n;
  logic [LEN_W-1:0]        cfg_len;
  logic signed [ACC_W-1:0] cfg_bias;
  logic                    cfg_relu;
  logic                    busy;

  int passCount;
  int totalCount;
  int beats[$];
  int expData;
  int expSat;

  mac_accumulator_if bus ();

  mac_accumulator #(
    .SHIFT (SHIFT)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cfg_len  (cfg_len),
    .cfg_bias (cfg_bias),
    .cfg_relu (cfg_relu),
    .bus      (bus),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    totalCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
  endtask

  // Window result from bias plus sum of beats, wrapped to ACC_W, floor((x + half) / 2^SHIFT).
  function automatic void refModel(input int len, input int bias, input bit relu,
                                   output int dataOut, output int satOut);
    int                      n;
    longint                  s;
    logic [63:0]             sBits;
    logic signed [ACC_W-1:0] w;
    longint                  r;
    n = (len == 0) ? 1 : len;
    s = bias;
    for (int i = 0; i < n; i++) s += beats[i];
    sBits = s;
    w = sBits[ACC_W-1:0];
    r = (longint'(w) + ((SHIFT > 0) ? (longint'(1) <<< (SHIFT-1)) : 0)) >>> SHIFT;
    if (relu && r < 0) r = 0;
    if (r > 127) begin
      dataOut = 127;
      satOut  = 1;
    end else if (r < -128) begin
      dataOut = -128;
      satOut  = 1;
    end else begin
      dataOut = int'(r);
      satOut  = 0;
    end
  endfunction

  // Drives one window; after the first beat the config inputs are scrambled.
  task automatic driveWindow(input int len, input int bias, input bit relu, input bit gaps);
    int n;
    n = (len == 0) ? 1 : len;
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0 && $urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 14'(int'($urandom));
        @(posedge clk);
        @(negedge clk);
      end
      if (i == 0) begin
        cfg_len  = 8'(len);
        cfg_bias = 24'(bias);
        cfg_relu = relu;
      end else begin
        cfg_len  = 8'($urandom);
        cfg_bias = 24'($urandom);
        cfg_relu = 1'($urandom);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = 14'(beats[i]);
      @(posedge clk);
      @(negedge clk);
      if (i == 0 && n > 1) checkOutput("busy_in_window", busy, 1);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic handshake(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    checkOutput({tag, "_valid_drop"}, bus.out_valid, 0);
    checkOutput({tag, "_ready_back"}, bus.in_ready, 1);
  endtask

  task automatic applyStimulus(input string tag, input int len, input int bias,
                               input bit relu, input bit gaps);
    driveWindow(len, bias, relu, gaps);
    refModel(len, bias, relu, expData, expSat);
    checkOutput({tag, "_valid"}, bus.out_valid, 1);
    checkOutput({tag, "_data"}, bus.out_data, expData);
    checkOutput({tag, "_sat"}, bus.out_sat, expSat);
    handshake(tag);
  endtask

  initial begin
    passCount     = 0;
    totalCount    = 0;
    reset_n       = 1'b0;
    cfg_len       = '0;
    cfg_bias      = '0;
    cfg_relu      = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_out_data", bus.out_data, 0);
    checkOutput("rst_out_sat", bus.out_sat, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_in_ready", bus.in_ready, 1);
    reset_n = 1'b1;
    @(negedge clk);

    // len=4, relu=1, positive sums
    beats = '{64, 128, 192, 256};
    driveWindow(4, 0, 1'b1, 1'b0);
    checkOutput("pos_valid", bus.out_valid, 1);
    checkOutput("pos_data", bus.out_data, 10);
    checkOutput("pos_sat", bus.out_sat, 0);
    handshake("pos");

    // Negative sum without and with ReLU
    beats = '{-100, -200, -300, -40};
    driveWindow(4, 0, 1'b0, 1'b0);
    checkOutput("neg_data", bus.out_data, -10);
    checkOutput("neg_sat", bus.out_sat, 0);
    handshake("neg");
    driveWindow(4, 0, 1'b1, 1'b0);
    checkOutput("relu_data", bus.out_data, 0);
    checkOutput("relu_sat", bus.out_sat, 0);
    handshake("relu");

    // Saturation at both rails with single-beat windows
    beats = '{8191};
    driveWindow(1, 0, 1'b0, 1'b0);
    checkOutput("satpos_valid", bus.out_valid, 1);
    checkOutput("satpos_data", bus.out_data, 127);
    checkOutput("satpos_sat", bus.out_sat, 1);
    handshake("satpos");
    beats = '{0};
    driveWindow(1, -100000, 1'b0, 1'b0);
    checkOutput("satneg_data", bus.out_data, -128);
    checkOutput("satneg_sat", bus.out_sat, 1);
    handshake("satneg");

    // Backpressure: result held, pending in_valid not consumed
    beats = '{64, 128, 192, 256};
    driveWindow(4, 0, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 14'(999);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("bp_valid", bus.out_valid, 1);
      checkOutput("bp_data", bus.out_data, 10);
      checkOutput("bp_sat", bus.out_sat, 0);
      checkOutput("bp_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    checkOutput("bp_ready_after", bus.in_ready, 1);
    checkOutput("bp_valid_after", bus.out_valid, 0);
    checkOutput("bp_idle_after", busy, 0);

    // Reset mid-window discards the partial accumulation
    beats = '{64, 64, 64, 64};
    cfg_len  = 8'd4;
    cfg_bias = 24'(5000);
    cfg_relu = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 14'(1000);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_valid", bus.out_valid, 0);
    checkOutput("midrst_data", bus.out_data, 0);
    checkOutput("midrst_sat", bus.out_sat, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    driveWindow(4, 0, 1'b0, 1'b0);
    checkOutput("postrst_data", bus.out_data, 4);
    checkOutput("postrst_sat", bus.out_sat, 0);
    handshake("postrst");

    // cfg_len=0 acts as one beat; bias change mid-window is ignored
    beats = '{64};
    driveWindow(0, 0, 1'b0, 1'b0);
    checkOutput("len0_valid", bus.out_valid, 1);
    checkOutput("len0_data", bus.out_data, 1);
    handshake("len0");
    beats = '{0, 0, 0};
    driveWindow(3, 1000, 1'b0, 1'b1);
    checkOutput("cfgchg_data", bus.out_data, 16);
    handshake("cfgchg");

    // Randomized windows with gaps against the reference model
    for (int w = 0; w < 16; w++) begin
      int len;
      int bias;
      bit relu;
      len  = int'($urandom_range(0, 10));
      bias = int'($urandom_range(0, 2 ** 21)) - 2 ** 20;
      relu = 1'($urandom);
      beats.delete();
      for (int b = 0; b < 11; b++) beats.push_back(int'($urandom_range(0, 16383)) - 8192);
      applyStimulus($sformatf("rand%0d", w), len, bias, relu, 1'b1);
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
